// File: rtl/msu_pkg.sv
// Shared types and defaults for the MSU-1 data fetch path.
package msu_pkg;

    localparam int SECTOR_BITS_DEF = 9;
    localparam int ADDR_W_DEF      = 32;
    localparam int SECNUM_W_DEF    = ADDR_W_DEF - SECTOR_BITS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } msu_state_e;

endpackage

// File: rtl/msu_data_fetch_if.sv
// HPS sector-transfer port. The fetch block (master) raises sd_rd with sd_lba
// stable and holds it until it sees sd_ack high; the HPS (slave) keeps sd_ack
// high for the whole transfer, pulsing sd_buff_wr once per byte, then drops it.
interface msu_data_fetch_if
    import msu_pkg::*;
#(
    parameter int SECTOR_BITS = SECTOR_BITS_DEF
);
    logic [31:0]            sd_lba;
    logic                   sd_rd;
    logic                   sd_ack;
    logic [SECTOR_BITS-1:0] sd_buff_addr;
    logic [7:0]             sd_buff_dout;
    logic                   sd_buff_wr;

    modport master (
        output sd_lba, sd_rd,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/msu_sector_ram.sv
// Two-sector byte buffer: one write port from the HPS, one registered read port.
module msu_sector_ram #(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);
    logic [7:0] mem [2**AW];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Only the output register is reset; the array contents are don't-care.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_q <= 8'h00;
        else         rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/msu_data_fetch.sv
// MSU-1 data port responder: keeps the current sector and the next one resident
// in a ping-pong buffer fed from the HPS, and reports busy/underrun status.
module msu_data_fetch
    import msu_pkg::*;
#(
    parameter int SECTOR_BITS = SECTOR_BITS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] msu_data_addr,
    input  logic              msu_data_seek,
    output logic [7:0]        msu_data_in,
    output logic              msu_status_data_busy,
    output logic              msu_data_underrun,
    msu_data_fetch_if.master  sd,
    output msu_state_e        fsm_state_o
);
    localparam int SW = ADDR_W - SECTOR_BITS;

    msu_state_e    state_q, state_d;
    logic [SW-1:0] tag_q [2];
    logic [SW-1:0] tag_d [2];
    logic [1:0]    valid_q, valid_d;
    logic          discard_q, discard_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;
    logic          sd_rd_q, sd_rd_d;
    logic [31:0]   sd_lba_q, sd_lba_d;
    logic          fetch_half_q, fetch_half_d;
    logic [SW-1:0] target_q, target_d;

    logic [SW-1:0] cur, nxt, target;
    logic          cur_res, nxt_held, have_target, ram_we;

    assign cur      = msu_data_addr[ADDR_W-1:SECTOR_BITS];
    assign nxt      = cur + SW'(1);
    assign cur_res  = valid_q[cur[0]] && (tag_q[cur[0]] == cur);
    assign nxt_held = valid_q[~cur[0]] && (tag_q[~cur[0]] == nxt);

    // A seek invalidates everything this cycle, so the new cur is always the target.
    always_comb begin
        have_target = 1'b0;
        target      = cur;
        if (msu_data_seek || !cur_res) begin
            have_target = 1'b1;
        end else if (!nxt_held) begin
            have_target = 1'b1;
            target      = nxt;
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        discard_d    = discard_q;
        busy_d       = busy_q;
        sd_rd_d      = sd_rd_q;
        sd_lba_d     = sd_lba_q;
        fetch_half_d = fetch_half_q;
        target_d     = target_q;
        underrun_d   = !cur_res;

        if (busy_q && cur_res && !discard_q && !msu_data_seek) busy_d = 1'b0;

        case (state_q)
            // Waiting for sd_ack low keeps a post-reset stale ack from being taken as ours.
            ST_IDLE: if (have_target && !sd.sd_ack) begin
                state_d          = ST_REQ;
                sd_rd_d          = 1'b1;
                sd_lba_d         = 32'(target);
                target_d         = target;
                fetch_half_d     = target[0];
                valid_d[target[0]] = 1'b0;
            end
            ST_REQ: if (sd.sd_ack) begin
                state_d = ST_XFER;
                sd_rd_d = 1'b0;
            end
            ST_XFER: if (!sd.sd_ack) begin
                state_d               = ST_IDLE;
                tag_d[fetch_half_q]   = target_q;
                valid_d[fetch_half_q] = !discard_q;
                discard_d             = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // The completing transfer needs no discard: the seek clears valid directly.
        if (msu_data_seek) begin
            valid_d = 2'b00;
            busy_d  = 1'b1;
            if (state_q == ST_REQ || (state_q == ST_XFER && sd.sd_ack)) discard_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            tag_q        <= '{default: '0};
            valid_q      <= 2'b00;
            discard_q    <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b1;
            sd_rd_q      <= 1'b0;
            sd_lba_q     <= 32'h0;
            fetch_half_q <= 1'b0;
            target_q     <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            discard_q    <= discard_d;
            busy_q       <= busy_d;
            underrun_q   <= underrun_d;
            sd_rd_q      <= sd_rd_d;
            sd_lba_q     <= sd_lba_d;
            fetch_half_q <= fetch_half_d;
            target_q     <= target_d;
        end
    end

    assign ram_we = sd.sd_buff_wr && sd.sd_ack && (state_q == ST_XFER);

    msu_sector_ram #(.AW(SECTOR_BITS + 1)) u_ram (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .we_i    (ram_we),
        .waddr_i ({fetch_half_q, sd.sd_buff_addr}),
        .wdata_i (sd.sd_buff_dout),
        .raddr_i ({cur[0], msu_data_addr[SECTOR_BITS-1:0]}),
        .rdata_o (msu_data_in)
    );

    assign msu_status_data_busy = busy_q;
    assign msu_data_underrun    = underrun_q;
    assign sd.sd_rd             = sd_rd_q;
    assign sd.sd_lba            = sd_lba_q;
    assign fsm_state_o          = state_q;
endmodule

// File: tb/tb_msu_data_fetch.sv
// Bench for msu_data_fetch: an HPS responder plus a resident-sector model.
module tb_msu_data_fetch;
    import msu_pkg::*;

    localparam int SB = 9;
    localparam int SW = 23;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        seek = 1'b0;
    logic [7:0]  data_in;
    logic        busy, underrun;
    msu_state_e  fsm_state;

    msu_data_fetch_if #(.SECTOR_BITS(SB)) sd_if ();

    msu_data_fetch #(.SECTOR_BITS(SB), .ADDR_W(32)) dut (
        .CLK                  (clk),
        .RST_N                (rst_n),
        .msu_data_addr        (addr),
        .msu_data_seek        (seek),
        .msu_data_in          (data_in),
        .msu_status_data_busy (busy),
        .msu_data_underrun    (underrun),
        .sd                   (sd_if),
        .fsm_state_o          (fsm_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Sectors currently held by the buffer; a sector always lands in half lba[0].
    logic [SW-1:0] res_q[$];
    bit            exp_busy = 1'b0;

    function automatic bit mdl_has(input logic [SW-1:0] s);
        foreach (res_q[i]) if (res_q[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void mdl_add(input logic [SW-1:0] s);
        for (int i = res_q.size() - 1; i >= 0; i--) if (res_q[i][0] == s[0]) res_q.delete(i);
        res_q.push_back(s);
    endfunction

    function automatic bit mdl_target(input logic [31:0] a, output logic [SW-1:0] t);
        logic [SW-1:0] c, n;
        c = a[31:9];
        n = c + 23'd1;
        t = c;
        if (!mdl_has(c)) return 1'b1;
        t = n;
        if (!mdl_has(n)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] pat(input logic [SW-1:0] s, input logic [8:0] off);
        return off[7:0] + s[7:0] * 8'd7 + s[15:8];
    endfunction

    task automatic do_seek(input logic [31:0] a);
        @(posedge clk); #1;
        addr = a;
        seek = 1'b1;
        @(posedge clk); #1;
        seek = 1'b0;
        res_q.delete();
        exp_busy = 1'b1;
    endtask

    // Serve the request the model predicts next; optionally pulse a seek at write seek_idx.
    task automatic serve_next(input int seek_idx, input logic [31:0] seek_addr, input string name);
        logic [SW-1:0] tgt;
        bit has, got, rd_bad, busy_bad, discarded, tgt_is_cur;
        has = mdl_target(addr, tgt);
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sd_if.sd_rd === 1'b1) begin got = 1'b1; break; end
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s req_timeout: sd_rd stayed 0 for 40 cycles, required request lba=%0h", name, tgt);
            return;
        end
        n_tests++;
        if (sd_if.sd_lba !== 32'(tgt)) begin
            n_fail++;
            $display("FAIL %s req_lba: got %0h, required %0h (has=%0d)", name, sd_if.sd_lba, tgt, has);
        end
        @(posedge clk); #1;
        sd_if.sd_ack = 1'b1;
        rd_bad = 1'b0; busy_bad = 1'b0; discarded = 1'b0;
        for (int i = 0; i < 512; i++) begin
            @(posedge clk); #1;
            sd_if.sd_buff_wr   = 1'b1;
            sd_if.sd_buff_addr = 9'(i);
            sd_if.sd_buff_dout = pat(tgt, 9'(i));
            if (i == seek_idx) begin addr = seek_addr; seek = 1'b1; end
            else seek = 1'b0;
            @(negedge clk);
            if (sd_if.sd_rd !== 1'b0) rd_bad = 1'b1;
            if (busy !== exp_busy) busy_bad = 1'b1;
            if (i == seek_idx) begin exp_busy = 1'b1; discarded = 1'b1; res_q.delete(); end
        end
        @(posedge clk); #1;
        sd_if.sd_buff_wr = 1'b0;
        seek = 1'b0;
        @(posedge clk); #1;
        sd_if.sd_ack = 1'b0;
        n_tests++;
        if (rd_bad) begin
            n_fail++;
            $display("FAIL %s rd_during_xfer: sd_rd=1 seen while ack high, required 0", name);
        end
        n_tests++;
        if (busy_bad) begin
            n_fail++;
            $display("FAIL %s busy_during_xfer: busy differed from required %0d", name, exp_busy);
        end
        if (!discarded) mdl_add(tgt);
        tgt_is_cur = (tgt == addr[31:9]);
        if (exp_busy && !discarded && tgt_is_cur) begin
            got = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (busy === 1'b0) begin got = 1'b1; break; end
            end
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("FAIL %s busy_fall: busy=%0d 4 cycles after ack fell, required 0", name, busy);
            end
            exp_busy = 1'b0;
        end
    endtask

    task automatic serve_until_idle(input string name);
        logic [SW-1:0] tgt;
        bit rd_seen;
        for (int k = 0; k < 4; k++) begin
            if (!mdl_target(addr, tgt)) break;
            serve_next(-1, 32'h0, name);
        end
        rd_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sd_if.sd_rd !== 1'b0) rd_seen = 1'b1;
        end
        n_tests++;
        if (rd_seen) begin
            n_fail++;
            $display("FAIL %s idle_no_req: sd_rd=1 (lba %0h), required no request", name, sd_if.sd_lba);
        end
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL %s underrun: got %0d, required 0", name, underrun);
        end
        n_tests++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_idle: got %0d, required %0d", name, busy, exp_busy);
        end
        n_tests++;
        if (data_in !== pat(addr[31:9], addr[8:0])) begin
            n_fail++;
            $display("FAIL %s data: addr %0h got %0h, required %0h", name, addr, data_in, pat(addr[31:9], addr[8:0]));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        addr  = 32'h0;
        repeat (3) @(negedge clk);
        n_tests++; if (data_in !== 8'h00)  begin n_fail++; $display("FAIL rst data_in: got %0h, required 0", data_in); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst busy: got %0d, required 0", busy); end
        n_tests++; if (underrun !== 1'b1)  begin n_fail++; $display("FAIL rst underrun: got %0d, required 1", underrun); end
        n_tests++; if (sd_if.sd_rd !== 1'b0) begin n_fail++; $display("FAIL rst sd_rd: got %0d, required 0", sd_if.sd_rd); end
        n_tests++; if (sd_if.sd_lba !== 32'h0) begin n_fail++; $display("FAIL rst sd_lba: got %0h, required 0", sd_if.sd_lba); end
        n_tests++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL rst state: got %0d, required IDLE", fsm_state); end
        // Leave reset with a seek to 0 so the first request coincides with it.
        @(posedge clk); #1;
        rst_n = 1'b1;
        seek  = 1'b1;
        @(posedge clk); #1;
        seek = 1'b0;
        res_q.delete();
        exp_busy = 1'b1;
    endtask

    task automatic test_seek_zero();
        serve_until_idle("seek0");
        @(posedge clk); #1;
        addr = 32'h5;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (data_in !== 8'h05) begin
            n_fail++;
            $display("FAIL seek0 byte5: got %0h, required 05", data_in);
        end
    endtask

    task automatic test_seek_a10();
        do_seek(32'h0000_0A10);
        serve_until_idle("seek_a10");
        n_tests++;
        if (data_in !== 8'h33) begin
            n_fail++;
            $display("FAIL seek_a10 byte: got %0h, required 33", data_in);
        end
    endtask

    task automatic test_boundary();
        bit un_bad, rd_got;
        do_seek(32'h0000_01FF);
        serve_until_idle("bnd_setup");
        @(posedge clk); #1;
        addr = 32'h0000_0200;
        un_bad = 1'b0; rd_got = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (underrun !== 1'b0) un_bad = 1'b1;
            if (sd_if.sd_rd === 1'b1) rd_got = 1'b1;
        end
        n_tests++;
        if (un_bad) begin n_fail++; $display("FAIL bnd underrun: saw 1 crossing 0x200, required 0"); end
        n_tests++;
        if (!rd_got || sd_if.sd_lba !== 32'h2) begin
            n_fail++;
            $display("FAIL bnd prefetch: rd=%0d lba=%0h within 2 cycles, required rd=1 lba=2", rd_got, sd_if.sd_lba);
        end
        serve_until_idle("bnd");
    endtask

    task automatic test_seek_mid_xfer();
        logic [31:0] a;
        do_seek(32'h0);
        serve_next(-1, 32'h0, "mid_s0");
        // Seek back into the sector being transferred: it must be fetched again.
        a = 32'h200 + 32'($urandom_range(0, 511));
        serve_next(100, a, "mid_s1");
        serve_until_idle("mid_after");
    endtask

    task automatic test_wrap();
        do_seek(32'hFFFF_FE00);
        serve_until_idle("wrap");
    endtask

    task automatic test_reset_mid_xfer();
        logic [31:0] a;
        bit got, rd_seen;
        a = $urandom;
        do_seek(a);
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sd_if.sd_rd === 1'b1) begin got = 1'b1; break; end
        end
        n_tests++;
        if (!got || sd_if.sd_lba !== 32'(a[31:9])) begin
            n_fail++;
            $display("FAIL rstx req: rd=%0d lba=%0h, required rd=1 lba=%0h", got, sd_if.sd_lba, a[31:9]);
        end
        @(posedge clk); #1;
        sd_if.sd_ack = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            sd_if.sd_buff_wr   = 1'b1;
            sd_if.sd_buff_addr = 9'(i);
            sd_if.sd_buff_dout = 8'hA5;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        sd_if.sd_buff_wr = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstx busy: got %0d, required 0", busy); end
        n_tests++; if (underrun !== 1'b1)   begin n_fail++; $display("FAIL rstx underrun: got %0d, required 1", underrun); end
        n_tests++; if (data_in !== 8'h00)   begin n_fail++; $display("FAIL rstx data_in: got %0h, required 0", data_in); end
        n_tests++; if (sd_if.sd_lba !== 32'h0) begin n_fail++; $display("FAIL rstx sd_lba: got %0h, required 0", sd_if.sd_lba); end
        n_tests++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL rstx state: got %0d, required IDLE", fsm_state); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sd_if.sd_rd !== 1'b0) rd_seen = 1'b1;
        end
        n_tests++;
        if (rd_seen) begin n_fail++; $display("FAIL rstx stale_ack: sd_rd=1 while ack still high, required 0"); end
        @(posedge clk); #1;
        sd_if.sd_ack = 1'b0;
        res_q.delete();
        exp_busy = 1'b0;
        serve_until_idle("rstx_after");
    endtask

    task automatic test_random_walk();
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_seek($urandom);
            end else begin
                @(posedge clk); #1;
                addr = addr + 32'($urandom_range(1, 700));
            end
            serve_until_idle("walk");
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sd_if.sd_ack       = 1'b0;
        sd_if.sd_buff_wr   = 1'b0;
        sd_if.sd_buff_addr = '0;
        sd_if.sd_buff_dout = 8'h00;
        test_reset();
        test_seek_zero();
        test_seek_a10();
        test_boundary();
        test_seek_mid_xfer();
        test_wrap();
        test_reset_mid_xfer();
        test_random_walk();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/msu_data_fetch.md
Name: msu_data_fetch

Overview:
- Storage-side responder for the MSU-1 data port.
- Consumes the byte address and seek pulse produced by the MSU register block.
- Supplies the byte at that address (msu_data_in) and the data-busy status bit.
- Fetches 512-byte sectors from the HPS sector interface into a two-sector ping-pong buffer, always prefetching one sector ahead of the read pointer.

Parameters:
- SECTOR_BITS, 9, log2 of sector size in bytes; buffer holds 2 sectors.
- ADDR_W, 32, width of msu_data_addr.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous, active-low.
- msu_data_addr  in  ADDR_W  current data byte address from the register block.
- msu_data_seek  in  1  single-cycle pulse: address was reloaded by a seek.
- msu_data_in  out  8  byte at msu_data_addr.
- msu_status_data_busy  out  1  seek in progress; data not yet valid.
- msu_data_underrun  out  1  current sector not resident (debug/status).
- sd_lba  out  32  sector number requested from HPS.
- sd_rd  out  1  read request; held until sd_ack rises.
- sd_ack  in  1  HPS transfer in progress.
- sd_buff_addr  in  SECTOR_BITS  byte offset of the incoming byte.
- sd_buff_dout  in  8  incoming byte.
- sd_buff_wr  in  1  write strobe for the incoming byte.

Behaviour:
- Clocking: one clock, CLK. RST_N is asynchronous, active-low.
- Reset values: msu_data_in=0, busy=0, underrun=1, sd_rd=0, sd_lba=0, both halves invalid, FSM=IDLE.
- Terms:
  - cur = msu_data_addr[ADDR_W-1:SECTOR_BITS].
  - nxt = cur+1, modulo 2^(ADDR_W-SECTOR_BITS); the wrap-around to 0 is required.
  - Half h (0/1) holds tag[h] and valid[h].
  - "cur resident" means valid[cur[0]] && tag[cur[0]]==cur.
- Buffer:
  - 2*2^SECTOR_BITS x 8 dual-port RAM.
  - Write port: at {fetch_half, sd_buff_addr} when sd_buff_wr && sd_ack && FSM==XFER.
  - Read port: at {cur[0], msu_data_addr[SECTOR_BITS-1:0]}.
  - msu_data_in is registered: 1-cycle latency from an address change.
- Fetch target priority, evaluated in IDLE:
  - (1) cur not resident -> fetch cur.
  - (2) else half ~cur[0] not holding nxt -> fetch nxt.
  - (3) else stay IDLE.
  - fetch_half = target[0]. Clear valid[fetch_half] when the request is issued.
- FSM:
  - IDLE -> REQ when a target exists. sd_lba=target, sd_rd=1.
  - REQ -> XFER on sd_ack=1. sd_rd drops the same cycle.
  - XFER -> IDLE on sd_ack falling. tag[fetch_half]=target; valid[fetch_half]=!discard.
- Seek:
  - msu_data_seek=1 -> valid[0]=valid[1]=0, busy=1.
  - If FSM is REQ or XFER, set discard=1. The HPS transfer is never aborted; the FSM completes the handshake and then re-evaluates.
  - discard clears on return to IDLE.
- Busy:
  - busy clears on the first cycle where busy && cur resident && !discard && !msu_data_seek.
  - busy never rises except on a seek.
- Simultaneous events:
  - A seek on the same cycle XFER completes: the seek wins, valid stays 0.
  - A seek on the same cycle IDLE issues a request: the request uses the new cur and discard is not set.
- Underrun: msu_data_underrun = !(cur resident), registered. While underrun=1, msu_data_in returns stale RAM content; this is not an error.
- Sequential reads crossing a sector boundary:
  - The old half now satisfies neither cur nor nxt, so nxt is refetched into it automatically.
  - Throughput therefore stays one sector ahead.
- Reset mid-transfer: all state clears immediately. An in-flight HPS ack is ignored until it falls; an IDLE-only guard prevents a new sd_rd while sd_ack=1.
- Writes from the HPS outside XFER are ignored.

Decomposition:
- Package msu_pkg:
  - SECTOR_BITS default.
  - FSM state typedef (IDLE, REQ, XFER).
  - Sector-number width localparam.
- Sub-module msu_sector_ram: inferred dual-port RAM with a registered read, 1024x8 by default.
- FSM, tags and busy logic stay in msu_data_fetch.

Test Plan:
- Seek to addr 0x00000000:
  - sd_lba=0 requested, ack, 512 writes (byte i=i[7:0]).
  - Busy falls after ack falls.
  - Second request sd_lba=1 follows.
  - msu_data_in=0x05 one cycle after addr=5.
- Seek to 0x00000A10:
  - cur=5 fetched into half 1, then 6 into half 0.
  - Byte at 0xA10 matches sector 5 offset 0x10.
  - Busy is 1 until sector 5 completes.
- Sequential addr 0x1FF->0x200 after both sectors resident:
  - underrun stays 0.
  - Request sd_lba=2 issued into half 0 within 2 cycles.
- Seek pulse during XFER of sector 1:
  - Transfer completes (no sd_rd until ack falls).
  - valid not set; new target requested.
  - Busy held throughout.
- Addr at top sector 0x7FFFFF (addr 0xFFFFFE00):
  - Prefetch requests sd_lba=0 (wrap).
- Assert RST_N=0 mid-XFER:
  - Outputs return to reset values asynchronously.
  - No sd_rd until sd_ack drops.
